simple_bus_mem_arb: RTL and testbench



---
 rtl/simple_bus_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/simple_bus_mem_arb.sv | 129 ++++++++++++
 tb/tb_simple_bus_mem_arb.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_bus_pkg.sv
// Shared types for the simple_bus memory target: bus op codes and the
// transaction FSM states.
package simple_bus_pkg;

    typedef enum logic [1:0] {
        MODE_NOP = 2'b00,
        MODE_RD  = 2'b01,
        MODE_WR  = 2'b10,
        MODE_RSV = 2'b11
    } bus_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACCESS,
        DONE
    } mem_state_e;

    function automatic logic mode_is_access(input bus_mode_e m);
        return (m == MODE_RD) || (m == MODE_WR);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the channel after the last winner has top priority,
// and the search wraps from NUM_CH-1 back to 0.
module rr_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_advance,
    output logic [NUM_CH-1:0] o_gnt
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic             w_found;
    int               w_best;
    int               w_best_dist;
    int               w_dist;

    // NOTE: every variable gets a default before the loop so no path through
    // this block leaves a value held, which would otherwise infer a latch.
    always_comb begin
        w_found     = 1'b0;
        w_best      = 0;
        w_best_dist = 0;
        w_dist      = 0;
        o_gnt       = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            w_dist = (j + NUM_CH - int'(r_ptr)) % NUM_CH;
            if (i_req[j] && (!w_found || w_dist < w_best_dist)) begin
                w_found     = 1'b1;
                w_best      = j;
                w_best_dist = w_dist;
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            o_gnt[j] = w_found && (w_best == j);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= PTR_W'((w_best + 1) % NUM_CH);
        end
    end

endmodule

// File: rtl/simple_bus_mem_arb.sv
// Word-addressed RAM shared by NUM_CH simple_bus requesters; one transaction
// at a time runs IDLE -> GRANT -> ACCESS -> DONE under round-robin arbitration.
module simple_bus_mem_arb
    import simple_bus_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [2*NUM_CH-1:0]      mode,
    input  logic [ADDR_W*NUM_CH-1:0] addr,
    input  logic [DATA_W*NUM_CH-1:0] wdata,
    output logic [NUM_CH-1:0]        gnt,
    output logic [NUM_CH-1:0]        rdy,
    output logic [NUM_CH-1:0]        err,
    output logic [DATA_W-1:0]        rdata
);

    localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

    mem_state_e        r_state, w_next;
    logic [NUM_CH-1:0] r_win, r_gnt, r_rdy, r_err;
    logic [NUM_CH-1:0] w_arb_req, w_arb_gnt;
    logic              w_advance, w_bad;
    bus_mode_e         r_mode, w_sel_mode;
    logic [ADDR_W-1:0] r_addr, w_sel_addr;
    logic [DATA_W-1:0] r_wdata, w_sel_wdata, r_rd, r_rdata;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] r_mem [DEPTH];

    // During GRANT the arbiter sees only the latched winner, so the pointer
    // advances past the channel actually served even if req has moved on.
    assign w_advance = (r_state == GRANT);
    assign w_arb_req = w_advance ? r_win : req;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_arb_req),
        .i_advance (w_advance),
        .o_gnt     (w_arb_gnt)
    );

    always_comb begin
        w_sel_mode  = MODE_NOP;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (r_win[j]) begin
                w_sel_mode  = bus_mode_e'(mode[2*j +: 2]);
                w_sel_addr  = addr[ADDR_W*j +: ADDR_W];
                w_sel_wdata = wdata[DATA_W*j +: DATA_W];
            end
        end
    end

    assign w_bad = !mode_is_access(r_mode) || ({1'b0, r_addr} >= DEPTH_L);
    assign w_idx = r_addr[IDX_W-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|req) w_next = GRANT;
            GRANT:   w_next = ACCESS;
            ACCESS:  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win   <= '0;
            r_gnt   <= '0;
            r_rdy   <= '0;
            r_err   <= '0;
            r_rdata <= '0;
            r_mode  <= MODE_NOP;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_rdy   <= '0;
            r_err   <= '0;
            r_rdata <= '0;
            case (r_state)
                IDLE: if (|req) r_win <= w_arb_gnt;
                GRANT: begin
                    r_gnt   <= r_win;
                    r_mode  <= w_sel_mode;
                    r_addr  <= w_sel_addr;
                    r_wdata <= w_sel_wdata;
                end
                DONE: begin
                    r_gnt   <= '0;
                    r_rdy   <= r_win;
                    r_err   <= w_bad ? r_win : '0;
                    r_rdata <= (!w_bad && r_mode == MODE_RD) ? r_rd : '0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the RAM and its read register carry no reset; a reset port would
    // force the array into flops. An asserted rst_n holds the FSM out of
    // ACCESS, which is what suppresses a write caught by reset.
    always_ff @(posedge clk) begin
        if (r_state == ACCESS && !w_bad) begin
            if (r_mode == MODE_WR) r_mem[w_idx] <= r_wdata;
            else                   r_rd         <= r_mem[w_idx];
        end
    end

    assign gnt   = r_gnt;
    assign rdy   = r_rdy;
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_simple_bus_mem_arb.sv
// Self-checking bench: three parameterisations of simple_bus_mem_arb driven
// with randomized traffic against an array-based memory and arbitration model.
module tb_simple_bus_mem_arb;

    localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10, RSV = 2'b11;

    logic clk;
    logic rst_n;

    logic [1:0]  a_req, a_gnt, a_rdy, a_err;
    logic [3:0]  a_mode;
    logic [15:0] a_addr, a_wdata;
    logic [7:0]  a_rdata;

    logic [3:0]  b_req, b_gnt, b_rdy, b_err;
    logic [7:0]  b_mode;
    logic [31:0] b_addr, b_wdata;
    logic [7:0]  b_rdata;

    logic [2:0]  c_req, c_gnt, c_rdy, c_err;
    logic [5:0]  c_mode;
    logic [11:0] c_addr;
    logic [95:0] c_wdata;
    logic [31:0] c_rdata;

    simple_bus_mem_arb #(.NUM_CH(2), .ADDR_W(8), .DATA_W(8), .DEPTH(200)) u_a (
        .clk(clk), .rst_n(rst_n), .req(a_req), .mode(a_mode), .addr(a_addr),
        .wdata(a_wdata), .gnt(a_gnt), .rdy(a_rdy), .err(a_err), .rdata(a_rdata));

    simple_bus_mem_arb #(.NUM_CH(4), .ADDR_W(8), .DATA_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .req(b_req), .mode(b_mode), .addr(b_addr),
        .wdata(b_wdata), .gnt(b_gnt), .rdy(b_rdy), .err(b_err), .rdata(b_rdata));

    simple_bus_mem_arb #(.NUM_CH(3), .ADDR_W(4), .DATA_W(32)) u_c (
        .clk(clk), .rst_n(rst_n), .req(c_req), .mode(c_mode), .addr(c_addr),
        .wdata(c_wdata), .gnt(c_gnt), .rdy(c_rdy), .err(c_err), .rdata(c_rdata));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ptr_m [3];
    int nch_m [3] = '{2, 4, 3};
    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];
    logic [31:0] mem_c [int];
    int a_addrs [$];
    int order_q [$];

    // ---------------- reference model ----------------
    function automatic int depth_of(input int dut);
        case (dut)
            0:       return 200;
            1:       return 256;
            default: return 16;
        endcase
    endfunction

    function automatic int rr_pick(input int p, input int n, input logic [3:0] reqs);
        for (int k = 0; k < n; k++) begin
            if (reqs[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [31:0] mdl_read(input int dut, input int k);
        case (dut)
            0:       return mem_a.exists(k) ? mem_a[k] : 'x;
            1:       return mem_b.exists(k) ? mem_b[k] : 'x;
            default: return mem_c.exists(k) ? mem_c[k] : 'x;
        endcase
    endfunction

    task automatic mdl_write(input int dut, input int k, input logic [31:0] wd);
        case (dut)
            0:       mem_a[k] = {24'h0, wd[7:0]};
            1:       mem_b[k] = {24'h0, wd[7:0]};
            default: mem_c[k] = wd;
        endcase
    endtask

    task automatic expect_op(input int dut, input logic [1:0] md, input logic [7:0] ad,
                             input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd);
        e_err = !(md == RD || md == WR) || (int'(ad) >= depth_of(dut));
        e_rd  = '0;
        if (!e_err && md == WR) mdl_write(dut, int'(ad), wd);
        if (!e_err && md == RD) e_rd = mdl_read(dut, int'(ad));
    endtask

    // ---------------- DUT access ----------------
    function automatic logic [3:0] get_gnt(input int dut);
        case (dut)
            0:       return {2'b00, a_gnt};
            1:       return b_gnt;
            default: return {1'b0, c_gnt};
        endcase
    endfunction

    function automatic logic [3:0] get_rdy(input int dut);
        case (dut)
            0:       return {2'b00, a_rdy};
            1:       return b_rdy;
            default: return {1'b0, c_rdy};
        endcase
    endfunction

    function automatic logic [3:0] get_err(input int dut);
        case (dut)
            0:       return {2'b00, a_err};
            1:       return b_err;
            default: return {1'b0, c_err};
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int dut);
        case (dut)
            0:       return {24'h0, a_rdata};
            1:       return {24'h0, b_rdata};
            default: return c_rdata;
        endcase
    endfunction

    task automatic drive(input int dut, input int ch, input logic r, input logic [1:0] md,
                         input logic [7:0] ad, input logic [31:0] wd);
        case (dut)
            0: begin
                a_req[ch] = r; a_mode[2*ch +: 2] = md;
                a_addr[8*ch +: 8] = ad; a_wdata[8*ch +: 8] = wd[7:0];
            end
            1: begin
                b_req[ch] = r; b_mode[2*ch +: 2] = md;
                b_addr[8*ch +: 8] = ad; b_wdata[8*ch +: 8] = wd[7:0];
            end
            default: begin
                c_req[ch] = r; c_mode[2*ch +: 2] = md;
                c_addr[4*ch +: 4] = ad[3:0]; c_wdata[32*ch +: 32] = wd;
            end
        endcase
    endtask

    // One complete transaction on a single channel; lat counts falling edges
    // from request to rdy (bounded), g2 is gnt after the second edge.
    task automatic txn(input int dut, input int ch, input logic [1:0] md, input logic [7:0] ad,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output logic [3:0] g2, output logic [3:0] rdy_after);
        logic [3:0] r;
        @(negedge clk);
        drive(dut, ch, 1'b1, md, ad, wd);
        lat = 0;
        g2  = '0;
        r   = '0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (lat == 2) g2 = get_gnt(dut);
            r = get_rdy(dut);
            if (r[ch]) break;
        end
        rd = get_rdata(dut);
        r  = get_err(dut);
        er = r[ch];
        drive(dut, ch, 1'b0, NOP, 8'h00, 32'h0);
        @(negedge clk);
        rdy_after = get_rdy(dut);
        ptr_m[dut] = (ch + 1) % nch_m[dut];
    endtask

    // All channels of one DUT write continuously; each completion is checked
    // against the round-robin model and the channel immediately reloads.
    task automatic run_contention(input int dut, input int n_txn, output int viol);
        int n, done, cyc, got, exp;
        logic [7:0]  ad [4];
        logic [31:0] wd [4];
        logic [3:0]  r;
        n = nch_m[dut];
        viol = 0;
        done = 0;
        cyc  = 0;
        order_q.delete();
        @(negedge clk);
        for (int ch = 0; ch < n; ch++) begin
            ad[ch] = 8'($urandom_range(0, depth_of(dut) - 1));
            wd[ch] = $urandom;
            drive(dut, ch, 1'b1, WR, ad[ch], wd[ch]);
        end
        while (done < n_txn && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if ($countones(get_gnt(dut)) > 1) viol++;
            r = get_rdy(dut);
            if (r != 4'b0) begin
                got = -1;
                for (int i = 0; i < 4; i++) if (r[i]) got = i;
                exp = rr_pick(ptr_m[dut], n, 4'b1111);
                checks++;
                if (got !== exp || $countones(r) != 1) begin
                    errors++;
                    $display("FAIL rr_winner dut%0d txn%0d: got rdy %b want ch%0d", dut, done, r, exp);
                end
                ptr_m[dut] = (exp + 1) % n;
                mdl_write(dut, int'(ad[exp]), wd[exp]);
                if (dut == 0) a_addrs.push_back(int'(ad[exp]));
                order_q.push_back(got);
                done++;
                if (done == n_txn) begin
                    for (int ch = 0; ch < n; ch++) drive(dut, ch, 1'b0, NOP, 8'h00, 32'h0);
                end else begin
                    ad[exp] = 8'($urandom_range(0, depth_of(dut) - 1));
                    wd[exp] = $urandom;
                    drive(dut, exp, 1'b1, WR, ad[exp], wd[exp]);
                end
            end
        end
        checks++;
        if (done != n_txn) begin
            errors++;
            $display("FAIL contention_timeout dut%0d: completed %0d want %0d", dut, done, n_txn);
            for (int ch = 0; ch < n; ch++) drive(dut, ch, 1'b0, NOP, 8'h00, 32'h0);
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        a_req = '0; a_mode = '0; a_addr = '0; a_wdata = '0;
        b_req = '0; b_mode = '0; b_addr = '0; b_wdata = '0;
        c_req = '0; c_mode = '0; c_addr = '0; c_wdata = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) ptr_m[i] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_gnt, a_rdy, a_err, a_rdata} !== 14'h0) begin
            errors++; $display("FAIL reset_a: got %h want 0", {a_gnt, a_rdy, a_err, a_rdata});
        end
        checks++;
        if ({b_gnt, b_rdy, b_err, b_rdata} !== 20'h0) begin
            errors++; $display("FAIL reset_b: got %h want 0", {b_gnt, b_rdy, b_err, b_rdata});
        end
        checks++;
        if ({c_gnt, c_rdy, c_err, c_rdata} !== 41'h0) begin
            errors++; $display("FAIL reset_c: got %h want 0", {c_gnt, c_rdy, c_err, c_rdata});
        end
    endtask

    task automatic test_single_wr_rd();
        logic [31:0] rd, e_rd;
        logic er, e_err;
        int lat;
        logic [3:0] g2, ra;
        expect_op(0, WR, 8'h10, 32'hA5, e_err, e_rd);
        a_addrs.push_back(8'h10);
        txn(0, 0, WR, 8'h10, 32'hA5, rd, er, lat, g2, ra);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d want 4", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", er); end
        checks++; if (g2 !== 4'b0001) begin errors++; $display("FAIL wr_gnt: got %b want 0001", g2); end
        checks++; if (ra !== 4'b0) begin errors++; $display("FAIL rdy_one_cycle: got %b want 0000", ra); end
        expect_op(0, RD, 8'h10, 32'h0, e_err, e_rd);
        txn(0, 0, RD, 8'h10, 32'h0, rd, er, lat, g2, ra);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", lat); end
        checks++; if (rd !== e_rd || e_rd !== 32'hA5) begin
            errors++; $display("FAIL rd_data: got %h want %h", rd, 32'hA5); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", er); end
    endtask

    task automatic test_random_rw();
        logic [31:0] rd, e_rd, wd;
        logic er, e_err;
        logic [1:0] md;
        logic [7:0] ad;
        int lat, ch;
        logic [3:0] g2, ra;
        for (int i = 0; i < 24; i++) begin
            ch = $urandom_range(0, 1);
            wd = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                md = WR;
                ad = 8'($urandom_range(0, 199));
                a_addrs.push_back(int'(ad));
            end else begin
                md = RD;
                ad = 8'(a_addrs[$urandom_range(0, a_addrs.size() - 1)]);
            end
            expect_op(0, md, ad, wd, e_err, e_rd);
            txn(0, ch, md, ad, wd, rd, er, lat, g2, ra);
            checks++;
            if (lat !== 4 || er !== e_err || (md == RD && rd !== e_rd)) begin
                errors++;
                $display("FAIL random_rw[%0d] ch%0d md%0d @%h: lat %0d err %b data %h want lat 4 err %b data %h",
                         i, ch, md, ad, lat, er, rd, e_err, e_rd);
            end
        end
    endtask

    task automatic test_errors();
        logic [1:0] md_t [8] = '{RSV, NOP, WR, RD, WR, WR, RD, RD};
        logic [7:0] ad_t [8] = '{8'h10, 8'h10, 8'd250, 8'd250, 8'd200, 8'd199, 8'd199, 8'h10};
        logic [31:0] rd, e_rd;
        logic er, e_err;
        int lat;
        logic [3:0] g2, ra;
        for (int i = 0; i < 8; i++) begin
            expect_op(0, md_t[i], ad_t[i], 32'h77 + i, e_err, e_rd);
            txn(0, i % 2, md_t[i], ad_t[i], 32'h77 + i, rd, er, lat, g2, ra);
            checks++;
            if (lat !== 4 || er !== e_err || ((e_err || md_t[i] == RD) && rd !== e_rd)) begin
                errors++;
                $display("FAIL error_case[%0d] md%0d @%0d: lat %0d err %b data %h want lat 4 err %b data %h",
                         i, md_t[i], ad_t[i], lat, er, rd, e_err, e_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, e_rd;
        logic er, e_err;
        int lat;
        logic [3:0] g2, ra;
        expect_op(0, WR, 8'h20, 32'h11, e_err, e_rd);
        txn(0, 0, WR, 8'h20, 32'h11, rd, er, lat, g2, ra);
        @(negedge clk);
        drive(0, 0, 1'b1, WR, 8'h20, 32'h3C);
        repeat (2) @(negedge clk);
        checks++;
        if (a_gnt !== 2'b01) begin errors++; $display("FAIL midreset_gnt_before: got %b want 01", a_gnt); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_gnt, a_rdy, a_err, a_rdata} !== 14'h0) begin
            errors++; $display("FAIL midreset_outputs: got %h want 0", {a_gnt, a_rdy, a_err, a_rdata});
        end
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 1'b0, NOP, 8'h00, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) ptr_m[i] = 0;
        expect_op(0, RD, 8'h20, 32'h0, e_err, e_rd);
        txn(0, 1, RD, 8'h20, 32'h0, rd, er, lat, g2, ra);
        checks++;
        if (rd !== e_rd || e_rd !== 32'h11 || er !== 1'b0 || lat !== 4) begin
            errors++; $display("FAIL midreset_mem: got %h err %b lat %0d want %h err 0 lat 4", rd, er, lat, 32'h11);
        end
    endtask

    task automatic test_contention();
        int exp_order [4] = '{0, 1, 0, 1};
        int viol;
        logic [31:0] rd;
        logic er;
        int lat, ch;
        logic [3:0] g2, ra;
        run_contention(0, 8, viol);
        for (int i = 0; i < 4 && i < order_q.size(); i++) begin
            checks++;
            if (order_q[i] !== exp_order[i]) begin
                errors++; $display("FAIL contention_order[%0d]: got ch%0d want ch%0d", i, order_q[i], exp_order[i]);
            end
        end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL contention_onehot: got %0d violations want 0", viol); end
        foreach (mem_a[k]) begin
            ch = $urandom_range(0, 1);
            txn(0, ch, RD, 8'(k), 32'h0, rd, er, lat, g2, ra);
            checks++;
            if (rd !== mem_a[k] || er !== 1'b0) begin
                errors++; $display("FAIL reread @%0d: got %h err %b want %h", k, rd, er, mem_a[k]);
            end
        end
    endtask

    task automatic test_wraparound();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int cnt [4] = '{0, 0, 0, 0};
        int viol;
        run_contention(1, 12, viol);
        for (int i = 0; i < 5 && i < order_q.size(); i++) begin
            checks++;
            if (order_q[i] !== exp_order[i]) begin
                errors++; $display("FAIL wrap_order[%0d]: got ch%0d want ch%0d", i, order_q[i], exp_order[i]);
            end
        end
        foreach (order_q[i]) if (order_q[i] >= 0 && order_q[i] < 4) cnt[order_q[i]]++;
        for (int ch = 0; ch < 4; ch++) begin
            checks++;
            if (cnt[ch] !== 3) begin errors++; $display("FAIL wrap_share ch%0d: got %0d want 3", ch, cnt[ch]); end
        end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL wrap_onehot: got %0d violations want 0", viol); end
    endtask

    task automatic test_param_sweep();
        logic [31:0] rd, e_rd, wd;
        logic er, e_err;
        int lat, ch;
        logic [7:0] ad;
        logic [3:0] g2, ra;
        expect_op(2, WR, 8'd15, 32'hDEADBEEF, e_err, e_rd);
        txn(2, 0, WR, 8'd15, 32'hDEADBEEF, rd, er, lat, g2, ra);
        checks++;
        if (lat !== 4 || er !== 1'b0) begin errors++; $display("FAIL wide_wr: lat %0d err %b want lat 4 err 0", lat, er); end
        expect_op(2, RD, 8'd15, 32'h0, e_err, e_rd);
        txn(2, 2, RD, 8'd15, 32'h0, rd, er, lat, g2, ra);
        checks++;
        if (rd !== 32'hDEADBEEF || rd !== e_rd || er !== 1'b0) begin
            errors++; $display("FAIL wide_rd: got %h err %b want deadbeef err 0", rd, er);
        end
        for (int i = 0; i < 6; i++) begin
            ch = $urandom_range(0, 2);
            ad = 8'($urandom_range(0, 14));
            wd = $urandom;
            expect_op(2, WR, ad, wd, e_err, e_rd);
            txn(2, ch, WR, ad, wd, rd, er, lat, g2, ra);
            expect_op(2, RD, ad, 32'h0, e_err, e_rd);
            txn(2, (ch + 1) % 3, RD, ad, 32'h0, rd, er, lat, g2, ra);
            checks++;
            if (rd !== e_rd || er !== 1'b0 || lat !== 4) begin
                errors++; $display("FAIL wide_random[%0d] @%0d: got %h err %b want %h", i, ad, rd, er, e_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_wr_rd();
        test_random_rw();
        test_errors();
        test_reset_mid();
        test_contention();
        test_wraparound();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
